sseg_scan_driver: RTL and testbench
===================================

// Module: sseg_scan_driver
// PURPOSE
//  Eight-digit time-multiplexed seven-segment driver. Sits downstream of the register-file display path.
//  Replaces the fixed single-digit AN/sseg/DP drive with a scanned display of 8 hex nibbles.
//  Latches a tear-free snapshot of its inputs once per frame. Decodes hex internally.
//  Adds anti-ghost blanking between digits and optional leading-zero suppression.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz slot, 125 Hz frame); legal range >= 2
//  BLANK_CYC    16      cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  hex_in      in   32  nibble i = hex_in[4i+3:4i] is shown on digit i (digit 0 = rightmost)
//  dp_in       in   8   dp_in[i]=1 lights the decimal point of digit i
//  digit_en    in   8   digit_en[i]=0 forces digit i dark (anode off)
//  blank_lz    in   1   1 = suppress leading zero digits
//  sseg        out  7   segments, active low, sseg[0]=a ... sseg[6]=g
//  AN          out  [0:7] anodes, active low; digit i drives AN[7-i]
//  DP          out  1   decimal point, active low
//  frame_done  out  1   one-cycle pulse when a new snapshot is loaded
// BEHAVIOUR
//  Reset (async, while reset_n=0):
//   - prescaler=0, index=0, snapshot regs (hex, dp, en)=0, load_pending=1
//   - AN=8'hFF, sseg=7'h7F, DP=1, frame_done=0
//  Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
//  On tick, index increments 0..7 and wraps from 7 to 0.
//  Snapshot load: hex_in, dp_in, digit_en and blank_lz are captured together with a frame_done pulse:
//   - on the first clk after reset release (clears load_pending), and
//   - on every tick with index==7, so the new frame starts at index 0.
//   - Inputs are never read at any other time; a mid-frame input change appears only in the next frame.
//  Outputs are registered and are a function of the current index, prescaler and snapshot:
//   - Blank window: prescaler < BLANK_CYC -> AN=8'hFF, sseg=7'h7F, DP=1.
//   - Otherwise AN has only bit 7-index low, unless digit index is suppressed.
//   - Digit index is suppressed when en[index]=0, or when:
//     blank_lz=1 and index!=0 and nibbles index..7 are all zero.
//   - A suppressed digit gives AN=8'hFF, sseg=7'h7F, DP=1.
//   - Digit 0 is never leading-zero suppressed.
//   - When lit: sseg=decode(nibble[index]), DP=~dp[index].
//   - Output latency is 1 clk after the prescaler/index change.
//  Decode table (hex -> sseg):
//   0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//   8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//  At most one AN bit is low in any cycle; no glitches (all outputs come straight from flops).
//  Reset asserted mid-frame: immediate dark outputs. After release the frame restarts at index 0 with a fresh snapshot.
// TESTING (REFRESH_DIV=4, BLANK_CYC=1 unless noted)
//  1. Reset held -> AN=FF, sseg=7F, DP=1, frame_done=0. Release -> frame_done pulses once on 1st clk.
//  2. hex_in=32'h89ABCDEF, en=FF, dp=0, blank_lz=0:
//     - each slot: 1 blank cycle, then 3 lit cycles;
//     - AN sequence FE,FD,FB,...,7F; sseg sequence 0E,06,21,46,03,08,10,00;
//     - frame_done every 32 cycles.
//  3. hex_in=32'h00000120, blank_lz=1, en=FF:
//     - digits 0-2 lit (40,24,79);
//     - digits 3-7 AN=FF for the whole slot;
//     - hex_in=0 -> only digit 0 lit with 40.
//  4. Change hex_in 1->2 while index=3:
//     - the rest of the frame still shows the old value;
//     - the new value appears from index 0 of the next frame, coincident with frame_done.
//  5. dp_in=8'h04, en=8'hFB:
//     - digit 2 slot fully dark despite dp=1;
//     - en=FF -> DP=0 only during the lit cycles of digit 2.
//  6. Assert reset_n=0 at index=5, mid-slot:
//     - outputs dark asynchronously, before the next edge;
//     - after release, index 0 and snapshot reload;
//     - check throughout that popcount(~AN) <= 1 every cycle.

Source files
------------

// File: rtl/sseg_scan_driver_if.sv
// Display bus between the register-file display path and the scan driver.
// The master drives the digit data and controls; the slave drives the panel.
interface sseg_scan_driver_if;
    logic [31:0] hex_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic [6:0]  sseg;
    logic [0:7]  AN;
    logic        DP;
    logic        frame_done;

    modport master (
        output hex_in, dp_in, digit_en, blank_lz,
        input  sseg, AN, DP, frame_done
    );

    modport slave (
        input  hex_in, dp_in, digit_en, blank_lz,
        output sseg, AN, DP, frame_done
    );
endinterface

// File: rtl/sseg_scan_driver.sv
// Eight-digit time-multiplexed seven-segment driver.
// A frame-aligned snapshot of the inputs is scanned out one digit per slot.
// Each slot opens with a short all-dark window to stop ghosting between
// digits. Leading zeros can optionally be blanked.
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    sseg_scan_driver_if.slave bus
);
    localparam int              PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   BLANK_LIM = PW'(BLANK_CYC);

    // Slot timing
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic          load_pending_q, load_pending_d;

    // Frame snapshot
    logic [31:0]   hex_q, hex_d;
    logic [7:0]    dp_q, dp_d;
    logic [7:0]    en_q, en_d;
    logic          blz_q, blz_d;

    // Registered panel outputs
    logic [6:0]    sseg_q, sseg_d;
    logic [7:0]    an_q, an_d;
    logic          dp_out_q, dp_out_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          load;
    logic [7:0]    nib_zero;
    logic [7:0]    upper_zero;
    logic [3:0]    cur_nib;
    logic          suppress;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Per-digit zero detect on the snapshot
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib_zero
            assign nib_zero[gi] = (hex_q[4*gi +: 4] == 4'h0);
        end
    endgenerate

    // upper_zero[i]: nibbles i..7 of the snapshot are all zero
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = 7; i >= 0; i--) begin
            run           = run & nib_zero[i];
            upper_zero[i] = run;
        end
    end

    // Prescaler, digit index and frame-aligned snapshot capture
    always_comb begin
        tick           = (presc_q == PRESC_MAX);
        presc_d        = tick ? '0 : presc_q + PW'(1);
        idx_d          = tick ? idx_q + 3'd1 : idx_q;
        // The pending flag forces a capture on the first clock after reset
        // so the panel never scans a whole frame of zeroed snapshot.
        load           = load_pending_q || (tick && (idx_q == 3'd7));
        load_pending_d = 1'b0;
        hex_d          = load ? bus.hex_in   : hex_q;
        dp_d           = load ? bus.dp_in    : dp_q;
        en_d           = load ? bus.digit_en : en_q;
        blz_d          = load ? bus.blank_lz : blz_q;
        frame_done_d   = load;
    end

    // Next panel drive from the current slot position and snapshot
    always_comb begin
        cur_nib  = hex_q[{idx_q, 2'b00} +: 4];
        suppress = !en_q[idx_q] ||
                   (blz_q && (idx_q != 3'd0) && upper_zero[idx_q]);
        sseg_d   = 7'h7F;
        an_d     = 8'hFF;
        dp_out_d = 1'b1;
        if ((presc_q >= BLANK_LIM) && !suppress) begin
            an_d     = ~(8'd1 << idx_q);
            sseg_d   = hex_to_seg(cur_nib);
            dp_out_d = ~dp_q[idx_q];
        end
    end

    // State and output registers; reset forces the panel dark immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q        <= '0;
            idx_q          <= 3'd0;
            load_pending_q <= 1'b1;
            hex_q          <= '0;
            dp_q           <= '0;
            en_q           <= '0;
            blz_q          <= 1'b0;
            sseg_q         <= 7'h7F;
            an_q           <= 8'hFF;
            dp_out_q       <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            load_pending_q <= load_pending_d;
            hex_q          <= hex_d;
            dp_q           <= dp_d;
            en_q           <= en_d;
            blz_q          <= blz_d;
            sseg_q         <= sseg_d;
            an_q           <= an_d;
            dp_out_q       <= dp_out_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Digit i maps to AN[7-i]; the packed value keeps that ordering.
    assign bus.sseg       = sseg_q;
    assign bus.AN         = an_q;
    assign bus.DP         = dp_out_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for the scanned seven-segment driver: a timing model predicts each
// cycle's panel drive from the slot arithmetic and queues it; a monitor
// pops and compares one entry per clock.
module tb_sseg_scan_driver;
    localparam int R     = 4;
    localparam int B     = 1;
    localparam int FRAME = 8 * R;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [6:0] sseg;
        logic [7:0] an;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_driver_if bus();

    sseg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n      = 0;     // rising edges since reset release
    logic [31:0] m_hex  = '0;
    logic [7:0]  m_dp   = '0;
    logic [7:0]  m_en   = '0;
    logic        m_blz  = 1'b0;

    // Expected drive visible after edge k: it reflects the slot position
    // reached after edge k-1, using the snapshot held at that time.
    function automatic exp_t ref_out(input int k, input logic [31:0] h,
                                     input logic [7:0] dpv, input logic [7:0] en,
                                     input logic blz);
        exp_t e;
        int   t, p, i;
        logic lit;
        t      = k - 1;
        p      = t % R;
        i      = (t / R) % 8;
        e.sseg = 7'h7F;
        e.an   = 8'hFF;
        e.dp   = 1'b1;
        e.fd   = (k == 1) || (k % FRAME == 0);
        if (p >= B) begin
            lit = en[i] && !(blz && (i != 0) && ((h >> (4 * i)) == 32'd0));
            if (lit) begin
                e.an   = 8'hFF ^ (8'h01 << i);
                e.sseg = SEG[(h >> (4 * i)) & 32'hF];
                e.dp   = ~dpv[i];
            end
        end
        return e;
    endfunction

    // Reference model: one expected entry per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                n      = 0;
                m_hex  = '0;
                m_dp   = '0;
                m_en   = '0;
                m_blz  = 1'b0;
                e.sseg = 7'h7F;
                e.an   = 8'hFF;
                e.dp   = 1'b1;
                e.fd   = 1'b0;
                exp_q.push_back(e);
            end else begin
                n++;
                exp_q.push_back(ref_out(n, m_hex, m_dp, m_en, m_blz));
                if ((n == 1) || (n % FRAME == 0)) begin
                    m_hex = bus.hex_in;
                    m_dp  = bus.dp_in;
                    m_en  = bus.digit_en;
                    m_blz = bus.blank_lz;
                end
            end
        end
    end

    // Monitor: compare every cycle's registered outputs against the queue
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            a.sseg = bus.sseg;
            a.an   = bus.AN;
            a.dp   = bus.DP;
            a.fd   = bus.frame_done;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t got sseg=%h AN=%h DP=%b fd=%b",
                         $time, a.sseg, a.an, a.dp, a.fd);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL panel at %0t n=%0d got sseg=%h AN=%h DP=%b fd=%b expected sseg=%h AN=%h DP=%b fd=%b",
                             $time, n, a.sseg, a.an, a.dp, a.fd, e.sseg, e.an, e.dp, e.fd);
                end
            end
            checks++;
            if ($countones(~a.an) > 1) begin
                errors++;
                $display("FAIL one_anode at %0t got AN=%h expected at most one low bit",
                         $time, a.an);
            end
        end
    end

    task automatic drive(input logic [31:0] h, input logic [7:0] dpv,
                         input logic [7:0] en, input logic blz, input string tag);
        bus.hex_in   = h;
        bus.dp_in    = dpv;
        bus.digit_en = en;
        bus.blank_lz = blz;
        $display("tx %s hex=%h dp=%h en=%h blank_lz=%b at %0t", tag, h, dpv, en, blz, $time);
    endtask

    task automatic check_dark(input string name);
        checks++;
        if ((bus.AN !== 8'hFF) || (bus.sseg !== 7'h7F) || (bus.DP !== 1'b1) ||
            (bus.frame_done !== 1'b0)) begin
            errors++;
            $display("FAIL %s got sseg=%h AN=%h DP=%b fd=%b expected sseg=7f AN=ff DP=1 fd=0",
                     name, bus.sseg, bus.AN, bus.DP, bus.frame_done);
        end
    endtask

    task automatic frames(input int f);
        repeat (f * FRAME) @(negedge clk);
    endtask

    // Wait (bounded) until the model's edge count sits at position pos in the frame
    task automatic wait_pos(input int pos, input string name);
        int k;
        k = 0;
        while ((n % FRAME) != pos && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((n % FRAME) != pos) begin
            errors++;
            $display("FAIL %s_timeout got pos=%0d expected pos=%0d", name, n % FRAME, pos);
        end
    endtask

    // Stimulus
    initial begin
        drive(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0, "reset_hold");
        repeat (3) @(negedge clk);
        check_dark("reset_state");
        reset_n = 1'b1;
        frames(2);

        drive(32'h00000120, 8'h00, 8'hFF, 1'b1, "lz_blank");
        frames(2);
        drive(32'h00000000, 8'h00, 8'hFF, 1'b1, "all_zero");
        frames(2);

        drive(32'h11111111, 8'h00, 8'hFF, 1'b0, "old_value");
        frames(1);
        wait_pos(3 * R + 1, "idx3");
        drive(32'h22222222, 8'h00, 8'hFF, 1'b0, "mid_frame");
        frames(2);

        drive(32'h76543210, 8'h04, 8'hFB, 1'b0, "dp_dark");
        frames(2);
        drive(32'h76543210, 8'h04, 8'hFF, 1'b0, "dp_lit");
        frames(2);

        drive(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0, "pre_reset");
        frames(1);
        wait_pos(5 * R + 2, "idx5");
        reset_n = 1'b0;
        #1;
        check_dark("async_reset");
        repeat (2) @(negedge clk);
        check_dark("reset_held");
        reset_n = 1'b1;
        frames(2);

        for (int it = 0; it < 30; it++) begin
            logic [31:0] h;
            h = $urandom >> (4 * $urandom_range(0, 8));
            drive(h, 8'($urandom), 8'($urandom | $urandom), 1'($urandom), "random");
            repeat ($urandom_range(5, 40)) @(negedge clk);
            if (it % 10 == 9) begin
                reset_n = 1'b0;
                #1;
                check_dark("random_reset");
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
